// File: rtl/uart_tx_arbiter.sv
// Round-robin, whole-message arbiter sharing one UART transmitter among N byte-stream requesters.
// A watchdog revokes the grant of an owner that holds i_req but stops sending.
//
// state | meaning
// IDLE  | no owner; arbitrate among pending i_req
// GRANT | owner's start/data passed to the TX core; watchdog running
// DRAIN | owner released or revoked; wait for the TX core to finish its byte
module uart_tx_arbiter #(
    parameter int N              = 3,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int CNT_W          = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     i_req,
    input  logic [N-1:0]     i_start,
    input  logic [8*N-1:0]   i_data,
    input  logic             i_tx_busy,
    output logic             o_tx_start,
    output logic [7:0]       o_tx_data,
    output logic [N-1:0]     o_grant,
    output logic [N-1:0]     o_busy,
    output logic             o_timeout
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0]    PTR_RST  = PW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     grant, grant_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             timeout, timeout_nxt;

    logic [PW-1:0]    winner;
    logic [N-1:0]     rot;
    int               off;
    int               sum;

    logic [7:0]       data_arr [N];
    logic             owner_req;
    logic             owner_start;
    logic [7:0]       owner_data;

    for (genvar k = 0; k < N; k++) begin : g_bytes
        assign data_arr[k] = i_data[8*k +: 8];
    end

    // The pointer always names the current (or last) owner.
    assign owner_req   = i_req[ptr];
    assign owner_start = i_start[ptr];
    assign owner_data  = data_arr[ptr];

    // Rotate requests so bit 0 is the requester just after the pointer, then take the lowest set bit.
    always_comb begin
        rot = N'({i_req, i_req} >> (int'(ptr) + 1));
        off = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end
        sum = int'(ptr) + 1 + off;
        if (sum >= N) begin
            sum = sum - N;
        end
        winner = PW'(sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            grant   <= '0;
            ptr     <= PTR_RST;
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            state   <= state_nxt;
            grant   <= grant_nxt;
            ptr     <= ptr_nxt;
            cnt     <= cnt_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant;
        ptr_nxt     = ptr;
        cnt_nxt     = '0;
        timeout_nxt = 1'b0;
        o_tx_start  = 1'b0;
        o_tx_data   = '0;

        unique case (state)
            IDLE: begin
                if (|i_req) begin
                    ptr_nxt   = winner;
                    grant_nxt = N'(1) << winner;
                    state_nxt = GRANT;
                end
            end

            GRANT: begin
                o_tx_start = owner_start;
                o_tx_data  = owner_data;
                if (!owner_req) begin
                    state_nxt = DRAIN;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = DRAIN;
                    timeout_nxt = 1'b1;
                end else if (!owner_start && !i_tx_busy) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            DRAIN: begin
                o_tx_data = owner_data;
                if (!i_tx_busy) begin
                    grant_nxt = '0;
                    state_nxt = IDLE;
                end
            end

            default: begin
                grant_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Non-owners always see a busy transmitter, so they hold off in their own wait states.
    assign o_busy    = ~grant | ({N{i_tx_busy}} & grant);
    assign o_grant   = grant;
    assign o_timeout = timeout;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between N byte-stream requesters: key echo, time-report sender, status reporter.
- Grants are whole-message: a requester keeps `i_req` high for its entire multi-byte message, so bytes from different sources never interleave.
- Round-robin selection among simultaneous requesters; a watchdog revokes a grant whose owner stalls.
- Sits between the requesters and the UART TX core.

Parameters:
- N, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 1_000_000, idle cycles (owner not starting, TX not busy) before forced release.
- CNT_W, 20, timeout counter width; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- i_req  input  N  per-requester message request, level, held for whole message
- i_start  input  N  per-requester byte start, held until own o_busy seen high
- i_data  input  8*N  per-requester byte; requester k uses bits [8k+7:8k]
- i_tx_busy  input  1  busy from UART TX core
- o_tx_start  output  1  start to UART TX core
- o_tx_data  output  8  byte to UART TX core
- o_grant  output  N  registered one-hot grant, all-zero when no owner
- o_busy  output  N  per-requester busy view
- o_timeout  output  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, immediate): state IDLE, o_grant=0, o_timeout=0, RR pointer=N-1 (requester 0 wins first), counter=0. o_tx_start=0, o_tx_data=0 follow combinationally.
- States:
  - IDLE: if any i_req, pick the first set bit searching from pointer+1 with wrap. Register o_grant one-hot and pointer=winner; go GRANT. Grant appears the cycle after i_req is sampled.
  - GRANT: o_tx_start=i_start[owner], o_tx_data=i_data[owner] (combinational mux, zero latency). If i_req[owner]=0, go DRAIN. Else if counter==TIMEOUT_CYCLES-1, go DRAIN and pulse o_timeout.
  - DRAIN: o_tx_start forced 0, o_tx_data held at owner's byte. o_grant stays. When i_tx_busy=0, clear o_grant and go IDLE.
- Counter: cleared on entering GRANT and on any cycle with i_start[owner]=1 or i_tx_busy=1. Otherwise increments in GRANT; held at 0 outside GRANT.
- o_busy[k] = i_tx_busy when o_grant[k]=1; 1 otherwise, including IDLE. Non-owners therefore never see an idle transmitter and stall in their own wait states.
- o_tx_start=0 and o_tx_data=0 in IDLE.
- Arbitration is evaluated only in IDLE. A request arriving during GRANT/DRAIN waits.
- Minimum release-to-next-grant gap is 2 cycles: the DRAIN exit cycle plus the IDLE decision.
- A requester whose grant was revoked by timeout and still holds i_req re-competes normally. The RR pointer gives other pending requesters priority first.
- i_start from a non-owner is ignored; no error flag.
- Owner dropping i_req while its byte is in flight: the byte completes (DRAIN waits on i_tx_busy), no new start.
- Reset mid-byte: the arbiter clears immediately. The UART core is assumed reset by the same signal.

Test Plan:
1. Only req0 sends "12:34:56\r\n" (10 bytes): o_grant=001 one cycle after req. o_tx_data sequence 0x31,0x32,0x3A,0x33,0x34,0x3A,0x35,0x36,0x0D,0x0A. o_busy[1]=o_busy[2]=1 throughout.
2. req0, req1, req2 rise in the same cycle, each sending 2 bytes: grants 001, 010, 100 in order. No byte interleaving. Grant gap ≥2 cycles after each DRAIN.
3. req1 asserted while req0 mid-message (byte 5 of 10): req1 waits; o_busy[1]=1 until req0 drops and TX goes idle; then o_grant=010.
4. TIMEOUT_CYCLES=16; req2 asserted with no starts: after 16 idle cycles o_timeout pulses 1 cycle, DRAIN→IDLE. With req0 pending, next grant=001.
5. Reset asserted during GRANT with i_tx_busy=1: o_grant=0, o_tx_start=0 in the same cycle. After release, req0 and req1 both high → grant 001.
6. Owner drops i_req while i_tx_busy=1: stays in DRAIN with o_tx_start=0 until busy falls, then o_grant=0 next cycle.
